// File: rtl/decode_queue.sv
// decode_queue: a small FIFO of pre-decoded MIPS instructions.
//
// Each raw word offered on in_* is decoded combinationally. When it is accepted,
// the decoded entry is written into the tail slot. A legal word is enqueued;
// an illegal word is consumed but dropped, and ill_count is bumped (saturating).
// The head slot is presented on out_* whenever out_valid is high.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    synchronous clear of the queue (ill_count kept)
//   in_valid/in_ready        input handshake; in_pc, in_data carry the raw instruction
//   out_valid/out_ready      output handshake; out_* carry the head entry's
//                            PC, raw word and decoded fields
//   count                    occupancy
//   ill_count                saturating count of dropped illegal words
module decode_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned ILL_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [31:0]                in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [31:0]                out_data,
  output logic [4:0]                 out_rs_addr,
  output logic [4:0]                 out_rt_addr,
  output logic [4:0]                 out_rw_addr,
  output logic                       out_uses_rs,
  output logic                       out_uses_rt,
  output logic                       out_uses_rw,
  output logic                       out_uses_imm,
  output logic [31:0]                out_imm,
  output logic                       out_is_branch_jump,
  output logic                       out_is_jump,
  output logic                       out_is_jump_reg,
  output logic                       out_is_mem,
  output logic                       out_mem_write,
  output logic [ADDR_WIDTH-1:0]      out_branch_target,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ILL_CNT_WIDTH-1:0]   ill_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           data;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rw;
    logic                  uses_rs;
    logic                  uses_rt;
    logic                  uses_rw;
    logic                  uses_imm;
    logic [31:0]           imm;
    logic                  is_bj;
    logic                  is_jump;
    logic                  is_jump_reg;
    logic                  is_mem;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] target;
  } entry_t;

  entry_t dec;
  logic   legal;

  logic [5:0]            op, funct;
  logic [4:0]            rs_f, rt_f, rd_f;
  logic [31:0]           sext, zext;
  logic [ADDR_WIDTH-1:0] pc_plus8, br_target, j_target;

  assign op        = in_data[31:26];
  assign funct     = in_data[5:0];
  assign rs_f      = in_data[25:21];
  assign rt_f      = in_data[20:16];
  assign rd_f      = in_data[15:11];
  assign sext      = {{16{in_data[15]}}, in_data[15:0]};
  assign zext      = {16'h0, in_data[15:0]};
  assign pc_plus8  = in_pc + ADDR_WIDTH'(8);
  assign br_target = in_pc + ADDR_WIDTH'(4) + ADDR_WIDTH'({sext[29:0], 2'b00});
  assign j_target  = {in_data[ADDR_WIDTH-3:0], 2'b00};

  always_comb begin
    dec      = '0;
    legal    = 1'b0;
    dec.pc   = in_pc;
    dec.data = in_data;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h04, 6'h06, 6'h07, 6'h2a, 6'h2b: begin
            legal  = 1'b1;
            dec.rs = rs_f;
            dec.rt = rt_f;
            dec.rw = rd_f;
          end
          // Immediate shifts: the shifted register travels on the rs port.
          6'h00, 6'h02, 6'h03: begin
            legal        = 1'b1;
            dec.rs       = rt_f;
            dec.rw       = rd_f;
            dec.imm      = {27'h0, in_data[10:6]};
            dec.uses_imm = 1'b1;
          end
          6'h08: begin
            legal           = 1'b1;
            dec.rs          = rs_f;
            dec.is_bj       = 1'b1;
            dec.is_jump     = 1'b1;
            dec.is_jump_reg = 1'b1;
          end
          6'h09: begin
            legal           = 1'b1;
            dec.rs          = rs_f;
            dec.rw          = 5'd31;
            dec.imm         = 32'(pc_plus8);
            dec.uses_imm    = 1'b1;
            dec.is_bj       = 1'b1;
            dec.is_jump     = 1'b1;
            dec.is_jump_reg = 1'b1;
          end
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h23: begin
        legal        = 1'b1;
        dec.rs       = rs_f;
        dec.rw       = rt_f;
        dec.imm      = sext;
        dec.uses_imm = 1'b1;
        dec.is_mem   = (op == 6'h23);
      end
      6'h0c, 6'h0d, 6'h0e: begin
        legal        = 1'b1;
        dec.rs       = rs_f;
        dec.rw       = rt_f;
        dec.imm      = zext;
        dec.uses_imm = 1'b1;
      end
      6'h0f: begin
        legal        = 1'b1;
        dec.rw       = rt_f;
        dec.imm      = {in_data[15:0], 16'h0};
        dec.uses_imm = 1'b1;
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        legal      = 1'b1;
        dec.rs     = rs_f;
        dec.rt     = rt_f;
        dec.is_bj  = 1'b1;
        dec.target = br_target;
      end
      6'h02: begin
        legal       = 1'b1;
        dec.is_bj   = 1'b1;
        dec.is_jump = 1'b1;
        dec.target  = j_target;
      end
      6'h03: begin
        legal        = 1'b1;
        dec.rw       = 5'd31;
        dec.imm      = 32'(pc_plus8);
        dec.uses_imm = 1'b1;
        dec.is_bj    = 1'b1;
        dec.is_jump  = 1'b1;
        dec.target   = j_target;
      end
      6'h2b: begin
        legal         = 1'b1;
        dec.rs        = rs_f;
        dec.rt        = rt_f;
        dec.imm       = sext;
        dec.uses_imm  = 1'b1;
        dec.is_mem    = 1'b1;
        dec.mem_write = 1'b1;
      end
      6'h10: begin
        if (rd_f == 5'h17 || rd_f == 5'h18 || rd_f == 5'h19) begin
          legal  = 1'b1;
          dec.rt = rt_f;
        end
      end
      default: ;
    endcase
    // Register $0 is never a real dependency.
    dec.uses_rs = (dec.rs != 5'd0);
    dec.uses_rt = (dec.rt != 5'd0);
    dec.uses_rw = (dec.rw != 5'd0);
  end

  logic [PtrW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [ILL_CNT_WIDTH-1:0] ill_q, ill_d;
  logic                     accept, push, pop;
  entry_t                   slots_q [DEPTH];
  entry_t                   head_e;

  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready & ~flush;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ill_d   = ill_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
    if (accept && !legal && ill_q != '1) ill_d = ill_q + ILL_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ill_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ill_q   <= ill_d;
    end
  end

  // Slot contents are qualified by count, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) slots_q[tail_q] <= dec;
  end

  assign head_e             = slots_q[head_q];
  assign out_pc             = head_e.pc;
  assign out_data           = head_e.data;
  assign out_rs_addr        = head_e.rs;
  assign out_rt_addr        = head_e.rt;
  assign out_rw_addr        = head_e.rw;
  assign out_uses_rs        = head_e.uses_rs;
  assign out_uses_rt        = head_e.uses_rt;
  assign out_uses_rw        = head_e.uses_rw;
  assign out_uses_imm       = head_e.uses_imm;
  assign out_imm            = head_e.imm;
  assign out_is_branch_jump = head_e.is_bj;
  assign out_is_jump        = head_e.is_jump;
  assign out_is_jump_reg    = head_e.is_jump_reg;
  assign out_is_mem         = head_e.is_mem;
  assign out_mem_write      = head_e.mem_write;
  assign out_branch_target  = head_e.target;
  assign count              = count_q;
  assign ill_count          = ill_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue (DEPTH=4, ADDR_WIDTH=16, ILL_CNT_WIDTH=8).
module tb_decode_queue;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_pc, out_pc, out_branch_target;
  logic [31:0] in_data, out_data, out_imm;
  logic [4:0]  out_rs_addr, out_rt_addr, out_rw_addr;
  logic        out_uses_rs, out_uses_rt, out_uses_rw, out_uses_imm;
  logic        out_is_branch_jump, out_is_jump, out_is_jump_reg, out_is_mem, out_mem_write;
  logic [2:0]  count;
  logic [7:0]  ill_count;

  decode_queue #(.DEPTH(4), .ADDR_WIDTH(16), .ILL_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr), .out_rw_addr(out_rw_addr),
    .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt), .out_uses_rw(out_uses_rw),
    .out_uses_imm(out_uses_imm), .out_imm(out_imm),
    .out_is_branch_jump(out_is_branch_jump), .out_is_jump(out_is_jump),
    .out_is_jump_reg(out_is_jump_reg), .out_is_mem(out_is_mem),
    .out_mem_write(out_mem_write), .out_branch_target(out_branch_target),
    .count(count), .ill_count(ill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cls = {is_branch_jump, is_jump, is_jump_reg, is_mem, mem_write}
  typedef struct {
    logic [31:0] data;
    logic [15:0] pc;
    logic        legal;
    logic [4:0]  rs, rt, rw;
    logic [31:0] imm;
    logic        imm_care;
    logic [4:0]  cls;
    logic [15:0] tgt;
    logic        tgt_care;
  } vec_t;

  vec_t        tbl [17];
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_ill = 8'd0;
  logic [31:0] q [$];
  int          sent, rcvd, mc;
  bit          pu, po;
  logic [127:0] act, expv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [15:0] pc);
    in_valid = 1'b1;
    in_data  = d;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic fill4();
    for (int i = 0; i < 4; i++) push(32'h2008_0000 | i, 16'(i * 4));
  endtask

  initial begin
    //            data          pc     lg rs  rt  rw  imm           ic cls       tgt     tc
    tbl[0]  = '{32'h00000018, 16'h0000, 0, 0,  0,  0, 32'h0,        0, 5'b00000, 16'h0,    0};
    tbl[1]  = '{32'h80000000, 16'h0000, 0, 0,  0,  0, 32'h0,        0, 5'b00000, 16'h0,    0};
    tbl[2]  = '{32'h20080005, 16'h0040, 1, 0,  0,  8, 32'h5,        1, 5'b00000, 16'h0,    0};
    tbl[3]  = '{32'h1109FFFF, 16'h0100, 1, 8,  9,  0, 32'h0,        0, 5'b10000, 16'h0100, 1};
    tbl[4]  = '{32'h0C000010, 16'h0200, 1, 0,  0, 31, 32'h208,      1, 5'b11000, 16'h0040, 1};
    tbl[5]  = '{32'h00084080, 16'h0000, 1, 8,  0,  8, 32'h2,        1, 5'b00000, 16'h0,    0};
    tbl[6]  = '{32'h00221820, 16'h0000, 1, 1,  2,  3, 32'h0,        0, 5'b00000, 16'h0,    0};
    tbl[7]  = '{32'h03E00008, 16'h0000, 1, 31, 0,  0, 32'h0,        0, 5'b11100, 16'h0,    0};
    tbl[8]  = '{32'h00A00009, 16'h0300, 1, 5,  0, 31, 32'h308,      1, 5'b11100, 16'h0,    0};
    tbl[9]  = '{32'h8FA9FFFC, 16'h0000, 1, 29, 0,  9, 32'hFFFFFFFC, 1, 5'b00010, 16'h0,    0};
    tbl[10] = '{32'hAFA90008, 16'h0000, 1, 29, 9,  0, 32'h8,        1, 5'b00011, 16'h0,    0};
    tbl[11] = '{32'h34848001, 16'h0000, 1, 4,  0,  4, 32'h00008001, 1, 5'b00000, 16'h0,    0};
    tbl[12] = '{32'h3C071234, 16'h0000, 1, 0,  0,  7, 32'h12340000, 1, 5'b00000, 16'h0,    0};
    tbl[13] = '{32'h4003B800, 16'h0000, 1, 0,  3,  0, 32'h0,        0, 5'b00000, 16'h0,    0};
    tbl[14] = '{32'h14220002, 16'h0050, 1, 1,  2,  0, 32'h0,        0, 5'b10000, 16'h005C, 1};
    tbl[15] = '{32'h08000100, 16'h0000, 1, 0,  0,  0, 32'h0,        0, 5'b11000, 16'h0400, 1};
    tbl[16] = '{32'h40000000, 16'h0000, 0, 0,  0,  0, 32'h0,        0, 5'b00000, 16'h0,    0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_data = '0;
    #12;
    chk("reset_state", {in_ready, out_valid, count, ill_count}, {1'b1, 1'b0, 3'd0, 8'd0});
    rst_n = 1'b1;
    step();

    // Table: one word at a time into an empty queue, then drain.
    for (int i = 0; i < 17; i++) begin
      push(tbl[i].data, tbl[i].pc);
      if (!tbl[i].legal) begin
        exp_ill = exp_ill + 8'd1;
        chk($sformatf("vec%0d_illegal", i), {out_valid, count, ill_count},
            {1'b0, 3'd0, exp_ill});
      end else begin
        act = {out_valid, count, out_pc, out_data, out_rs_addr, out_rt_addr, out_rw_addr,
               out_uses_rs, out_uses_rt, out_uses_rw,
               tbl[i].imm_care ? out_uses_imm : 1'b0,
               tbl[i].imm_care ? out_imm : 32'h0,
               out_is_branch_jump, out_is_jump, out_is_jump_reg, out_is_mem, out_mem_write,
               tbl[i].tgt_care ? out_branch_target : 16'h0};
        expv = {1'b1, 3'd1, tbl[i].pc, tbl[i].data, tbl[i].rs, tbl[i].rt, tbl[i].rw,
                tbl[i].rs != 5'd0, tbl[i].rt != 5'd0, tbl[i].rw != 5'd0,
                tbl[i].imm_care, tbl[i].imm, tbl[i].cls, tbl[i].tgt};
        chk($sformatf("vec%0d_decode", i), act, expv);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk($sformatf("vec%0d_drained", i), {out_valid, count}, {1'b0, 3'd0});
      end
    end

    // Fill to DEPTH, then stream 12 more words with push and pop together.
    for (int i = 0; i < 4; i++) q.push_back(32'h2008_0000 | i);
    fill4();
    sent = 4; rcvd = 0; mc = 4;
    chk("full_ready", {in_ready, count}, {1'b0, 3'd4});
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && rcvd < 16; cyc++) begin
      in_valid = (sent < 16);
      in_data  = 32'h2008_0000 | sent;
      in_pc    = 16'(sent * 4);
      chk("wrap_ready", {127'h0, in_ready}, {127'h0, mc < 4});
      if (mc > 0) chk("wrap_data", {96'h0, out_data}, {96'h0, q[0]});
      pu = in_valid && (mc < 4);
      po = (mc > 0);
      if (po) begin void'(q.pop_front()); rcvd++; end
      if (pu) begin q.push_back(in_data); sent++; end
      mc = mc + int'(pu) - int'(po);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_done", {rcvd, out_valid}, {32'd16, 1'b0});

    // Illegal word while full is refused and not counted.
    fill4();
    in_valid = 1'b1; in_data = 32'h00000018;
    step();
    in_valid = 1'b0;
    chk("ill_while_full", {in_ready, count, ill_count}, {1'b0, 3'd4, exp_ill});

    // Flush with 3 entries, a push and a pop all offered together.
    out_ready = 1'b1;
    step();
    chk("pre_flush_count", count, 3'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h20080007;
    chk("flush_in_ready", in_ready, 1'b1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_clear", {out_valid, count, ill_count}, {1'b0, 3'd0, exp_ill});
    step();
    chk("flush_word_lost", {out_valid, count}, {1'b0, 3'd0});

    // ill_count saturation.
    in_valid = 1'b1; in_data = 32'h80000000;
    for (int i = 0; i < 261; i++) step();
    in_valid = 1'b0;
    chk("ill_saturate", {count, ill_count}, {3'd0, 8'hFF});

    // Asynchronous reset pulse between edges with the queue full.
    fill4();
    chk("pre_reset_full", count, 3'd4);
    rst_n = 1'b0;
    #2;
    chk("async_reset", {count, in_ready, out_valid, ill_count}, {3'd0, 1'b1, 1'b0, 8'd0});
    #1;
    rst_n = 1'b1;
    step();
    push(32'h00084080, 16'h0000);
    chk("post_reset_sll",
        {out_valid, count, out_rs_addr, out_rw_addr, out_uses_imm, out_imm, ill_count},
        {1'b1, 3'd1, 5'd8, 5'd8, 1'b1, 32'h2, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
